// File: rtl/shift_seq_pkg.sv
// Shared types for the shift sequencer: operation codes, FSM state encoding
// and the base-3 split of the shift amount that drives one digit per cycle.
// Optional build macro used by the sequencer: SHIFT_SEQ_EARLY_EXIT_EN.
package shift_seq_pkg;

  localparam logic [1:0] MODE_SLL  = 2'd0;
  localparam logic [1:0] MODE_SRA  = 2'd1;
  localparam logic [1:0] MODE_ROR  = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D0   = 3'd1,
    ST_D1   = 3'd2,
    ST_D2   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Base-3 digits of a 4-bit amount; d2 is only ever 0 or 1 for 0..15.
  typedef struct packed {
    logic [1:0] d2;
    logic [1:0] d1;
    logic [1:0] d0;
  } digits_t;

  function automatic digits_t base3_digits(input logic [3:0] v);
    digits_t d;
    d.d0 = 2'(v % 4'd3);
    d.d1 = 2'((v / 4'd3) % 4'd3);
    d.d2 = 2'(v / 4'd9);
    return d;
  endfunction

endpackage

// File: rtl/shift_seq_step.sv
// Purpose: one combinational shift step (SLL / SRA / ROR) by an amount 0..9.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       amount,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);

  localparam int SW = $clog2(WIDTH) + 1;

  // Left-shift distance for the wrap-around half of a rotate.
  logic [SW-1:0] rot_lsh;
  assign rot_lsh = SW'(WIDTH) - SW'(amount);

  // Select the shifted operand; the reserved mode passes acc through untouched.
  always_comb begin
    result = acc;
    case (mode)
      MODE_SLL: result = acc << amount;
      MODE_SRA: result = $unsigned($signed(acc) >>> amount);
      MODE_ROR: begin
        if (amount != 4'd0) begin
          result = (acc >> amount) | (acc << rot_lsh);
        end
      end
      default:  result = acc;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Purpose: multi-cycle SLL/SRA/ROR, resolving the 4-bit amount one base-3 digit (weights 1,3,9) per cycle.
// Latency: 3 cycles accept->OutValid; 1..3 when SHIFT_SEQ_EARLY_EXIT_EN is defined (result unchanged).
// Backpressure: single op in flight; InReady low until the result is taken, result held while OutReady=0.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               InValid,
  output logic               InReady,
  input  logic [WIDTH-1:0]   ShiftIn,
  input  logic [SHAMT_W-1:0] ShiftVal,
  input  logic [1:0]         Mode,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [WIDTH-1:0]   ShiftOut,
  output logic               OutErr,
  output logic               Busy
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [1:0]       mode_q;
  digits_t          dig_q;
  logic [3:0]       step_amt;
  logic [WIDTH-1:0] step_res;
  logic             accept;

  assign accept = InValid && InReady;

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: walk the three digits, optionally skipping trailing zero digits.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_D0;
        end
      end
      ST_D0: begin
        state_nxt = ST_D1;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        if (mode_q == MODE_RSVD || (dig_q.d1 == 2'd0 && dig_q.d2 == 2'd0)) begin
          state_nxt = ST_DONE;
        end
`endif
      end
      ST_D1: begin
        state_nxt = ST_D2;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        if (dig_q.d2 == 2'd0) begin
          state_nxt = ST_DONE;
        end
`endif
      end
      ST_D2: state_nxt = ST_DONE;
      ST_DONE: begin
        if (OutReady) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; ShiftOut is forced to zero outside DONE.
  always_comb begin
    InReady  = (state == ST_IDLE) && !rst;
    Busy     = (state != ST_IDLE);
    OutValid = (state == ST_DONE);
    ShiftOut = (state == ST_DONE) ? acc : '0;
    OutErr   = (state == ST_DONE) && (mode_q == MODE_RSVD);
  end

  // Shift distance for this cycle: current digit times its weight (0..2, 0/3/6, 0/9).
  always_comb begin
    step_amt = 4'd0;
    case (state)
      ST_D0:   step_amt = {2'b00, dig_q.d0};
      ST_D1:   step_amt = 4'({2'b00, dig_q.d1} * 4'd3);
      ST_D2:   step_amt = 4'({2'b00, dig_q.d2} * 4'd9);
      default: step_amt = 4'd0;
    endcase
  end

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc    (acc),
    .amount (step_amt),
    .mode   (mode_q),
    .result (step_res)
  );

  // Accumulator and operand latches: capture on accept, update once per digit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mode_q <= MODE_SLL;
      dig_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc    <= ShiftIn;
            mode_q <= Mode;
            dig_q  <= base3_digits(4'(ShiftVal));
          end
        end
        ST_D0, ST_D1, ST_D2: acc <= step_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed table, backpressure and reset corners, then random ops
// checked against a plain-arithmetic shift model. Expected latency follows SHIFT_SEQ_EARLY_EXIT_EN.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic [15:0] ShiftIn;
  logic [3:0]  ShiftVal;
  logic [1:0]  Mode;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] ShiftOut;
  logic        OutErr;
  logic        Busy;

  int n_chk  = 0;
  int n_pass = 0;

  shift_sequencer #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .ShiftIn  (ShiftIn),
    .ShiftVal (ShiftVal),
    .Mode     (Mode),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .ShiftOut (ShiftOut),
    .OutErr   (OutErr),
    .Busy     (Busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  s;
    logic [1:0]  m;
    logic [15:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl[13];

  // Reference result: the whole shift done at once with wide arithmetic.
  function automatic logic [15:0] ref_shift(input logic [15:0] a, input logic [3:0] s, input logic [1:0] m);
    logic [31:0] w;
    int          v;
    case (m)
      2'd0: begin w = {16'h0, a} << s; return w[15:0]; end
      2'd1: begin v = $signed(a); v = v >>> s; return v[15:0]; end
      2'd2: begin w = {a, a} >> s; return w[15:0]; end
      default: return a;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] s, input logic [1:0] m);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    if (m == 2'd3) return 1;
    if (s <= 4'd2) return 1;
    if (s <= 4'd8) return 2;
    return 3;
`else
    return 3;
`endif
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, hold it until accepted, then scramble the inputs.
  task automatic accept(input string nm, input logic [15:0] a, input logic [3:0] s, input logic [1:0] m);
    int cnt = 0;
    ShiftIn  = a;
    ShiftVal = s;
    Mode     = m;
    InValid  = 1'b1;
    while (!InReady && cnt < 20) begin
      tick();
      cnt++;
    end
    if (cnt >= 20) check({nm, " accept timeout"}, 32'(cnt), 32'd0);
    tick();
    InValid  = 1'b0;
    ShiftIn  = 16'($urandom);
    ShiftVal = 4'($urandom);
    Mode     = 2'($urandom);
  endtask

  // Count active edges after acceptance until OutValid shows up.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!OutValid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string nm, input logic [15:0] a, input logic [3:0] s, input logic [1:0] m,
                       input logic [15:0] e, input logic ee, input int hold);
    int lat;
    accept(nm, a, s, m);
    check({nm, " busy"}, {30'h0, InReady, Busy}, 32'b01);
    wait_result(lat);
    check({nm, " lat"}, lat, exp_lat(s, m));
    check({nm, " out"}, {15'h0, OutValid, ShiftOut}, {15'h0, 1'b1, e});
    check({nm, " err"}, 32'(OutErr), 32'(ee));
    if (hold > 0) begin
      OutReady = 1'b0;
      repeat (hold) tick();
      check({nm, " hold"}, {14'h0, OutValid, OutErr, ShiftOut}, {14'h0, 1'b1, ee, e});
      OutReady = 1'b1;
    end
    tick();
    check({nm, " ret"}, {30'h0, OutValid, InReady}, 32'b01);
  endtask

  initial begin
    int lat;
    logic [15:0] ra;
    logic [3:0]  rs;
    logic [1:0]  rm;

    tbl[0]  = '{16'h0001, 4'd15, 2'd0, 16'h8000, 1'b0};
    tbl[1]  = '{16'h8000, 4'd15, 2'd1, 16'hFFFF, 1'b0};
    tbl[2]  = '{16'h7FF0, 4'd4,  2'd1, 16'h07FF, 1'b0};
    tbl[3]  = '{16'h1234, 4'd4,  2'd2, 16'h4123, 1'b0};
    tbl[4]  = '{16'h8001, 4'd15, 2'd2, 16'h0003, 1'b0};
    tbl[5]  = '{16'hBEEF, 4'd7,  2'd3, 16'hBEEF, 1'b1};
    tbl[6]  = '{16'h00FF, 4'd8,  2'd0, 16'hFF00, 1'b0};
    tbl[7]  = '{16'hA5A5, 4'd0,  2'd0, 16'hA5A5, 1'b0};
    tbl[8]  = '{16'hABCD, 4'd0,  2'd2, 16'hABCD, 1'b0};
    tbl[9]  = '{16'h4000, 4'd15, 2'd1, 16'h0000, 1'b0};
    tbl[10] = '{16'h0003, 4'd1,  2'd0, 16'h0006, 1'b0};
    tbl[11] = '{16'h9000, 4'd5,  2'd1, 16'hFC80, 1'b0};
    tbl[12] = '{16'h000F, 4'd12, 2'd2, 16'h00F0, 1'b0};

    rst = 1'b1; InValid = 1'b0; ShiftIn = '0; ShiftVal = '0; Mode = '0; OutReady = 1'b1;
    tick();
    check("reset outs", {27'h0, InReady, OutValid, OutErr, Busy, |ShiftOut}, 32'd0);
    rst = 1'b0;
    #1;
    check("reset ready", 32'(InReady), 32'd1);

    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].s, tbl[i].m, tbl[i].exp, tbl[i].err, i % 3);
    end

    // Backpressure: result held, second request waits until the first is drained.
    OutReady = 1'b0;
    accept("bp1", 16'h0001, 4'd3, 2'd0);
    wait_result(lat);
    check("bp1 out", {15'h0, OutValid, ShiftOut}, {15'h0, 1'b1, 16'h0008});
    ShiftIn = 16'h0002; ShiftVal = 4'd1; Mode = 2'd0; InValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp stall%0d", c), {14'h0, OutValid, InReady, ShiftOut}, {14'h0, 1'b1, 1'b0, 16'h0008});
    end
    OutReady = 1'b1;
    tick();
    check("bp drain", {29'h0, OutValid, InReady, Busy}, 32'b010);
    tick();
    InValid = 1'b0;
    check("bp2 busy", {30'h0, InReady, Busy}, 32'b01);
    wait_result(lat);
    check("bp2 lat", lat, exp_lat(4'd1, 2'd0));
    check("bp2 out", 32'(ShiftOut), 32'h0004);
    tick();

    // Reset while in D1 discards the operation.
    accept("rst op", 16'h1234, 4'd9, 2'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rst mid", {15'h0, OutValid, Busy, ShiftOut}, 32'd0);
    tick();
    tick();
    check("rst hold", {15'h0, OutValid, Busy, ShiftOut}, 32'd0);
    rst = 1'b0;
    #1;
    do_op("post rst", 16'h00FF, 4'd8, 2'd0, 16'hFF00, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom);
      rs = 4'($urandom_range(0, 15));
      rm = 2'($urandom_range(0, 3));
      do_op($sformatf("rnd%0d", i), ra, rs, rm, ref_shift(ra, rs, rm), rm == 2'd3, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
